// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit
//   Instruction fetch stage with a DEPTH-entry prefetch FIFO of {pc, instr} pairs between the
//   instruction memory (IM) and decode (ID). It allows one outstanding IM request. A redirect
//   flushes the FIFO, and any response that is still in flight is thrown away when it arrives.
//
//   Optional build macro IF_PREFETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   redirect_valid/_pc       flush and restart fetch at redirect_pc (bits [1:0] forced to 0)
//   im_req_valid/_ready/_addr   IM request channel (valid/ready)
//   im_rsp_valid/_data       IM response channel (valid only)
//   id_valid/_ready/_pc/_instr  FIFO head towards decode
//   perf_fetch_cnt           (macro only) entries pushed into the FIFO
//   perf_drop_cnt            (macro only) responses discarded after a redirect
module if_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            im_req_valid,
    input  logic            im_req_ready,
    output logic [XLEN-1:0] im_req_addr,
    input  logic            im_rsp_valid,
    input  logic [31:0]     im_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr
`ifdef IF_PREFETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_drop_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;   // pointer with wrap bit
    localparam int unsigned CW = PW + 1;   // occupancy + inflight without overflow

    typedef enum logic [1:0] {StIdle, StWaitRsp, StDrop} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            run_q;
    // pend: request is on the bus but has not been accepted yet; its address is frozen in
    // req_addr. stale: a redirect arrived while it was pending, so its response is unwanted.
    logic            pend_q, pend_d;
    logic            stale_q, stale_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic            empty, full, inflight, space_ok;
    logic            req_fire, push, pop, drop;
    logic [PW-1:0]   count;
    logic [CW-1:0]   occupancy;
    logic [AW-1:0]   wr_idx, rd_idx;
    logic            unused_pc_lsb;

    assign wr_idx        = wr_ptr_q[AW-1:0];
    assign rd_idx        = rd_ptr_q[AW-1:0];
    assign unused_pc_lsb = ^redirect_pc[1:0];

    always_comb begin
        empty        = (wr_ptr_q == rd_ptr_q);
        full         = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        count        = wr_ptr_q - rd_ptr_q;
        inflight     = (state_q != StIdle);
        occupancy    = CW'(count) + CW'(inflight);
        space_ok     = (occupancy < CW'(DEPTH));
        // run_q keeps the request low until the first clock after reset release
        im_req_valid = run_q && (state_q == StIdle) && (pend_q || space_ok);
        im_req_addr  = pend_q ? req_addr_q : fetch_pc_q;
        req_fire     = im_req_valid && im_req_ready;
        id_valid     = !empty;
        id_pc        = empty ? '0 : pc_mem[rd_idx];
        id_instr     = empty ? '0 : instr_mem[rd_idx];
        push         = (state_q == StWaitRsp) && im_rsp_valid && !redirect_valid;
        pop          = id_valid && id_ready && !redirect_valid;
        drop         = im_rsp_valid &&
                       ((state_q == StDrop) || ((state_q == StWaitRsp) && redirect_valid));
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pend_d     = pend_q;
        stale_d    = stale_q;
        req_addr_d = req_addr_q;

        if (redirect_valid) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (req_fire) begin
                    state_d = (redirect_valid || stale_q) ? StDrop : StWaitRsp;
                    pend_d  = 1'b0;
                    stale_d = 1'b0;
                end else if (im_req_valid) begin
                    pend_d     = 1'b1;
                    req_addr_d = im_req_addr;
                    stale_d    = stale_q || redirect_valid;
                end
            end
            StWaitRsp: begin
                if (im_rsp_valid) begin
                    state_d = StIdle;
                end else if (redirect_valid) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                // A redirect here keeps us dropping; the response still ends the outstanding
                // request, so it always returns to idle.
                if (im_rsp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            run_q      <= 1'b0;
            pend_q     <= 1'b0;
            stale_q    <= 1'b0;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            run_q      <= 1'b1;
            pend_q     <= pend_d;
            stale_q    <= stale_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_idx]    <= fetch_pc_q;
            instr_mem[wr_idx] <= im_rsp_data;
        end
    end

`ifdef IF_PREFETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (drop) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Parametrised successor to the single-register PC/IF stage.
- Decouples instruction fetch from decode with a DEPTH-entry prefetch FIFO of {pc, instr} pairs.
- Talks to IM over a valid/ready request channel plus a valid-only response channel; allows one outstanding request.
- Handles branch/jump redirects by flushing the FIFO and dropping any stale in-flight response.

Parameters:
- XLEN, 32, address/PC width.
- DEPTH, 4, FIFO entries; power of two, >=2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- redirect_valid  in  1  flush and restart fetch this cycle.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced 0).
- im_req_valid  out  1  fetch request valid.
- im_req_ready  in  1  IM accepts request.
- im_req_addr  out  XLEN  fetch address.
- im_rsp_valid  in  1  response data valid; at most one per accepted request, earliest the cycle after acceptance.
- im_rsp_data  in  32  instruction word.
- id_valid  out  1  FIFO head valid.
- id_ready  in  1  decode consumes head.
- id_pc  out  XLEN  PC of head entry.
- id_instr  out  32  instruction of head entry.

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE, fetch_pc=RESET_PC, FIFO empty, inflight=0.
  - Outputs: im_req_valid=0, im_req_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0.
- FIFO:
  - Read/write pointers carry an extra wrap bit (log2(DEPTH)+1 bits).
  - empty when pointers are equal; full when indices are equal and wrap bits differ.
  - id_valid = !empty; id_pc/id_instr driven from the head entry.
  - Pop occurs when id_valid && id_ready.
- Space rule: a request may be issued only if count + inflight < DEPTH, where count is FIFO occupancy and inflight is the one-bit outstanding flag. A response therefore never finds the FIFO full.
- FSM states:
  - IDLE:
    - Assert im_req_valid when the space rule holds; im_req_addr = fetch_pc.
    - On im_req_valid && im_req_ready -> WAIT_RSP, inflight=1.
    - im_req_valid may first rise in the first cycle after reset release.
  - WAIT_RSP:
    - im_req_valid=0.
    - On im_rsp_valid: push {fetch_pc, im_rsp_data}, fetch_pc += 4 (mod 2^XLEN, wraps), inflight=0, -> IDLE.
  - DROP:
    - im_req_valid=0.
    - On im_rsp_valid: discard data, inflight=0, -> IDLE. No push; fetch_pc unchanged.
- Request stability: once im_req_valid=1, im_req_addr and im_req_valid are held until im_req_ready, even if a redirect arrives.
- Redirect (highest priority; any pop/push in the same cycle is ignored):
  - FIFO is flushed (pointers reset); id_valid=0 next cycle.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - If WAIT_RSP with no im_rsp_valid this cycle -> DROP.
  - If WAIT_RSP with im_rsp_valid this cycle -> response discarded, -> IDLE.
  - If IDLE with im_req_valid && !im_req_ready: the request stays pending. When it is accepted, the FSM goes to DROP, and fetch then restarts at the redirect PC.
  - If IDLE and the request is accepted this cycle -> DROP.
  - If DROP -> stays DROP.
- Simultaneous push and pop: count unchanged. A pop on a full FIFO is legal.
- Latency: im_rsp_valid in cycle N -> id_valid=1 in cycle N+1 (no bypass). Minimum back-to-back throughput is one instruction every 2 cycles (single outstanding).

Optional Feature:
- Macro: IF_PREFETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_fetch_cnt[31:0] (count of pushed entries) and perf_drop_cnt[31:0] (count of discarded responses).
  - Both counters reset to 0, wrap at 2^32, and are not cleared by redirect.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, IM always ready, 1-cycle response, id_ready=1 -> im_req_addr sequence 0x0, 0x4, 0x8; id_pc sequence 0x0, 0x4, 0x8 with matching id_instr; id_valid rises one cycle after each im_rsp_valid.
- id_ready=0, DEPTH=4 -> exactly 4 entries accepted; im_req_valid stays 0 while count+inflight=4. id_ready=1 for one cycle -> one new request issued to 0x10.
- Redirect to 0x103 while in WAIT_RSP -> FIFO empties; next response discarded (perf_drop_cnt=1 with macro defined); next request address 0x100; first id_pc after the redirect is 0x100.
- Redirect in the same cycle as im_rsp_valid and id_ready -> nothing pushed, FSM in IDLE; next im_req_addr equals the redirect PC.
- im_req_ready held 0 for 3 cycles with a redirect to 0x200 in cycle 1 -> im_req_addr stays at the old PC until accepted; that response is dropped; next request 0x200.
- Assert rst low mid-WAIT_RSP -> all outputs return to their reset values immediately (async); after release, fetch restarts at RESET_PC.
